busarb_rr: RTL and testbench
============================

# busarb_rr

Parametrised N-requester bus arbiter with selectable fixed-priority or round-robin policy, grant hold while the owner keeps requesting, and a bounded hold time that forces release. It replaces the fixed 3-requester arbiter. It sits between the requester agents and the shared-bus mux, and drives the mux select via `gnt_id`.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership. 0 disables the timeout.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `r`  in  N: request vector, bit i = requester i. Level-sensitive.
- `mode`  in  1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `out`  out  N: one-hot grant, registered. All-zero = bus free.
- `gnt_id`  out  clog2(N): index of the current owner. Valid only when `busy`=1.
- `busy`  out  1: high when `out` is non-zero.

## Operation
- Reset values: `out`=0, `gnt_id`=0, `busy`=0, round-robin pointer `ptr`=0, hold counter `cnt`=0.
- Two states, IDLE (no owner) and OWN (owner k).
- IDLE:
  - `r`=0: stay in IDLE.
  - Otherwise pick a winner w. Go to OWN(w) with `out`=1<<w, `gnt_id`=w, `cnt`=1.
  - In mode 1, also set `ptr`=(w+1) mod N.
- Pick rule:
  - Mode 0: lowest set index of `r`.
  - Mode 1: first set index scanning upward from `ptr`, wrapping N-1 to 0.
- OWN(k):
  - `r[k]`=0: release. Go to IDLE and clear `out` next edge.
  - `r[k]`=1 and `MAX_HOLD`≠0 and `cnt`==`MAX_HOLD`: forced release. Go to IDLE.
  - Otherwise stay in OWN(k), `cnt`++.
  - Requests from other bits are ignored while in OWN. There is no preemption.
- Every release leaves exactly one IDLE (turnaround) cycle with `out`=0.
- After a timeout, the former owner competes normally:
  - Mode 0: it wins again if it is the lowest requester.
  - Mode 1: `ptr` has already moved past it.
- `mode` is sampled only in IDLE. A change during OWN takes effect at the next arbitration.
- `cnt` width is clog2(MAX_HOLD+1) and it never wraps.
- `out` is always one-hot or zero. `busy` = |`out`.
- Reset asserted mid-ownership clears all outputs immediately, asynchronously.
- First arbitration after reset release uses `ptr`=0.

## Timing
- Grant latency: `r` sampled at edge t in IDLE gives `out` valid after edge t, i.e. 1 cycle.
- Release latency: `r[k]` low sampled at edge t gives `out`=0 after edge t.
- Earliest re-grant is after edge t+1.
- Maximum continuous ownership is `MAX_HOLD` cycles, then 1 idle cycle.
- Mode 1 worst-case wait for a requester holding `r` high: (N-1)·(MAX_HOLD+1) cycles.
- All outputs come from registers. There is no combinational path from `r` to `out`.

## Structure
- Package `busarb_pkg`:
  - `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1.
  - State encoding `ST_IDLE`/`ST_OWN`.
  - Index-width helper function.
- Sub-module `busarb_pick`: combinational rotating priority picker.
  - Inputs: `r`[N], `ptr`, `mode`.
  - Outputs: one-hot `win`[N], `win_id`, `any`.
  - Mode 0 forces start index 0.
- The top level holds the state, `cnt`, `ptr` and the output registers.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
- Reset: hold `rst`=1 with `r`=4'b1111, deassert. `out`=0 during reset; `out`=4'b0001 one edge after release in mode 0.
- Fixed priority: `r`=4'b1010, mode 0. `out`=4'b0010. Drop `r[1]`: one cycle of `out`=0, then `out`=4'b1000.
- Round-robin: `r`=4'b1111 held, mode 1. Owner sequence 0,1,2,3,0. Each ownership lasts 4 cycles followed by 1 idle cycle.
- Timeout, mode 0: `r`=4'b0001 held. `out`=4'b0001 for 4 cycles, 0 for 1 cycle, then `out`=4'b0001 again with `cnt` restarted.
- Wrap and mid-reset: mode 1, `ptr`=3, `r`=4'b0001 gives `out`=4'b0001. Assert `rst` mid-hold: `out`, `busy` and `gnt_id` go to 0 without a clock edge.
- Mode switch during OWN: change `mode` 0→1 while `out`=4'b0100. Ownership continues unchanged; the next arbitration uses round-robin from `ptr`.

Source files
------------

// File: rtl/busarb_pkg.sv
// Shared definitions for the round-robin / fixed-priority bus arbiter.
`timescale 1ns/1ps
package busarb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   // Index width for a range of n values; never below 1 so vectors stay legal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/busarb_pick.sv
// Combinational rotating-priority picker: first set request at or above the start index, wrapping.
`timescale 1ns/1ps
module busarb_pick
   import busarb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  r,
   input  logic [IW-1:0] ptr,
   input  logic          mode,
   output logic [N-1:0]  win,
   output logic [IW-1:0] win_id,
   output logic          any
);

   logic [IW-1:0] start;
   logic [IW-1:0] idx;
   logic          found;

   // Fixed priority is just the rotating scan anchored at index 0.
   assign start = (mode == MODE_RR) ? ptr : '0;
   assign any   = |r;

   always_comb begin
      win    = '0;
      win_id = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = IW'((int'(start) + i) % N);
         if (!found && r[idx]) begin
            found       = 1'b1;
            win[idx]    = 1'b1;
            win_id      = idx;
         end
      end
   end

endmodule

// File: rtl/busarb_rr.sv
// N-requester bus arbiter: fixed or round-robin pick, grant held while requested, bounded hold time.
`timescale 1ns/1ps
module busarb_rr
   import busarb_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IW       = idx_w(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  r,
   input  logic          mode,
   output logic [N-1:0]  out,
   output logic [IW-1:0] gnt_id,
   output logic          busy
);

   // state   | meaning
   // ST_IDLE | bus free; arbitrate among r this cycle
   // ST_OWN  | requester gnt_id owns the bus; cnt = cycles owned so far

   localparam int             CW       = idx_w(MAX_HOLD + 1);
   localparam logic [CW-1:0]  CNT_SAT  = {CW{1'b1}};
   localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_HOLD);
   localparam logic [IW-1:0]  LAST_ID  = IW'(N - 1);

   state_t        state, state_nx;
   logic [N-1:0]  out_nx;
   logic [IW-1:0] gnt_id_nx;
   logic [IW-1:0] ptr, ptr_nx;
   logic [CW-1:0] cnt, cnt_nx;

   logic [N-1:0]  pick_win;
   logic [IW-1:0] pick_id;
   logic          pick_any;
   logic          owner_req;
   logic          timeout;

   busarb_pick #(.N(N)) u_pick (
      .r      (r),
      .ptr    (ptr),
      .mode   (mode),
      .win    (pick_win),
      .win_id (pick_id),
      .any    (pick_any)
   );

   assign owner_req = r[gnt_id];
   assign timeout   = (MAX_HOLD != 0) && (cnt == CNT_MAX);
   assign busy      = |out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         out    <= '0;
         gnt_id <= '0;
         ptr    <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_nx;
         out    <= out_nx;
         gnt_id <= gnt_id_nx;
         ptr    <= ptr_nx;
         cnt    <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      out_nx    = out;
      gnt_id_nx = gnt_id;
      ptr_nx    = ptr;
      cnt_nx    = cnt;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_nx  = ST_OWN;
               out_nx    = pick_win;
               gnt_id_nx = pick_id;
               cnt_nx    = CW'(1);
               if (mode == MODE_RR) begin
                  ptr_nx = (pick_id == LAST_ID) ? '0 : pick_id + IW'(1);
               end
            end
         end
         ST_OWN: begin
            // Other requesters are ignored here; release always passes through one idle cycle.
            if (!owner_req || timeout) begin
               state_nx = ST_IDLE;
               out_nx   = '0;
            end else if (cnt != CNT_SAT) begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: begin
            state_nx = ST_IDLE;
            out_nx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_busarb_rr.sv
// Self-checking bench for busarb_rr (N=4, MAX_HOLD=4): directed scenarios plus randomized traffic vs a cycle model.
`timescale 1ns/1ps
module tb_busarb_rr;

   localparam int N        = 4;
   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] r   = '0;
   logic       mode = 1'b0;
   logic [3:0] out;
   logic [1:0] gnt_id;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: owner index (-1 = bus free), cycles held, round-robin start.
   int m_owner;
   int m_held;
   int m_ptr;

   busarb_rr #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk    (clk),
      .rst    (rst),
      .r      (r),
      .mode   (mode),
      .out    (out),
      .gnt_id (gnt_id),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
   endtask

   task automatic model_step();
      int start;
      int w;
      if (m_owner < 0) begin
         if (r != 4'b0000) begin
            start = mode ? m_ptr : 0;
            w = -1;
            for (int i = 0; i < N; i++) begin
               if (w < 0 && r[(start + i) % N]) w = (start + i) % N;
            end
            m_owner = w;
            m_held  = 1;
            if (mode) m_ptr = (w + 1) % N;
         end
      end else if (!r[m_owner] || m_held == MAX_HOLD) begin
         m_owner = -1;
      end else begin
         m_held++;
      end
   endtask

   // One clock: step the model with the inputs the DUT sampled, then compare after the edge.
   task automatic cycle();
      logic [3:0] exp_out;
      @(posedge clk);
      model_step();
      #1;
      exp_out = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      chk("out", out, exp_out);
      chk("busy", busy, (m_owner >= 0) ? 1 : 0);
      if (m_owner >= 0) chk("gnt_id", gnt_id, m_owner);
   endtask

   task automatic hard_reset(input logic [3:0] rv, input logic mv);
      rst  = 1'b1;
      r    = rv;
      mode = mv;
      model_reset();
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_hold_out", out, 0);
      end
      rst = 1'b0;
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_out", out, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_gnt_id", gnt_id, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();

      // Reset with all requesting, fixed priority
      hard_reset(4'b1111, 1'b0);
      cycle();
      chk("reset_first_grant", out, 4'b0001);

      // Fixed priority, then release with one idle turnaround
      hard_reset(4'b1010, 1'b0);
      cycle();
      chk("fixed_grant", out, 4'b0010);
      r = 4'b1000;
      cycle();
      chk("fixed_turnaround", out, 4'b0000);
      cycle();
      chk("fixed_regrant", out, 4'b1000);

      // Round-robin rotation with timeout on every ownership
      hard_reset(4'b1111, 1'b1);
      for (int k = 0; k < 5; k++) begin
         repeat (MAX_HOLD) begin
            cycle();
            chk("rr_owner", out, 1 << (k % N));
         end
         if (k < 4) begin
            cycle();
            chk("rr_gap", out, 0);
         end
      end

      // Timeout in fixed mode: same owner wins again with a fresh hold count
      hard_reset(4'b0001, 1'b0);
      for (int k = 0; k < 2; k++) begin
         repeat (MAX_HOLD) begin
            cycle();
            chk("to_own", out, 4'b0001);
         end
         cycle();
         chk("to_gap", out, 4'b0000);
      end

      // Pointer wrap from 3 to 0, then asynchronous reset mid-hold
      hard_reset(4'b0100, 1'b1);
      cycle();
      r = 4'b0000;
      cycle();
      r = 4'b0001;
      cycle();
      chk("wrap_grant", out, 4'b0001);
      cycle();
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      chk("mid_rst_out", out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_gnt_id", gnt_id, 0);
      @(negedge clk);
      rst = 1'b0;

      // Mode switch while owning: takes effect only at the next arbitration
      hard_reset(4'b0010, 1'b1);
      cycle();
      r = 4'b0000;
      cycle();
      mode = 1'b0;
      r    = 4'b0100;
      cycle();
      chk("ms_grant", out, 4'b0100);
      mode = 1'b1;
      r    = 4'b0111;
      repeat (MAX_HOLD - 1) begin
         cycle();
         chk("ms_hold", out, 4'b0100);
      end
      cycle();
      chk("ms_release", out, 4'b0000);
      cycle();
      chk("ms_rr_pick", out, 4'b0100);

      // Randomized traffic with sticky requests, occasional mode flips and resets
      for (int c = 0; c < 2000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         end
         if ($urandom_range(0, 29) == 0) mode = ~mode;
         if ($urandom_range(0, 199) == 0) mid_reset();
         else cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
